// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with load extraction and exception report
module mem_stage #(
    parameter int EX_TO_MEM_WD = 167,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_RF_WD = 104
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    except_valid,
    output logic [15:0]             excepttype_o,
    output logic [31:0]             except_pc,
    output logic [31:0]             bad_vaddr
);

    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic [31:0]             rdata_hold;
    logic                    hold_vld;

    // stall[3] stops the EX/MEM boundary, stall[4] stops the MEM/WB boundary
    logic stop_ex;
    logic stop_mem;
    assign stop_ex  = stall[3];
    assign stop_mem = stall[4];

    // Stage register: reset/flush clear it, a stall of EX only inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (flush) begin
            bus_r <= '0;
        end else if (stop_ex && !stop_mem) begin
            bus_r <= '0;
        end else if (!stop_ex) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    // SRAM data is only valid for one cycle; keep the first-cycle word while MEM is held
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_vld   <= 1'b0;
            rdata_hold <= '0;
        end else if (!stop_ex || !stop_mem) begin
            hold_vld   <= 1'b0;
        end else if (!hold_vld) begin
            hold_vld   <= 1'b1;
            rdata_hold <= data_sram_rdata;
        end
    end

    // Field decode of the registered execute bus
    logic [15:0] excepttype;
    logic        op_lb, op_lbu, op_lh, op_lhu, op_lw;
    logic        hi_we, lo_we;
    logic [31:0] hi_data, lo_data;
    logic [31:0] pc;
    logic [3:0]  ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign excepttype = bus_r[166:151];
    assign op_lb      = bus_r[150];
    assign op_lbu     = bus_r[149];
    assign op_lh      = bus_r[148];
    assign op_lhu     = bus_r[147];
    assign op_lw      = bus_r[146];
    assign hi_we      = bus_r[142];
    assign hi_data    = bus_r[141:110];
    assign lo_we      = bus_r[109];
    assign lo_data    = bus_r[108:77];
    assign pc         = bus_r[76:45];
    assign ram_sel    = bus_r[42:39];
    assign sel_rf_res = bus_r[38];
    assign rf_we      = bus_r[37];
    assign rf_waddr   = bus_r[36:32];
    assign ex_result  = bus_r[31:0];

    // Store opcodes, the SRAM enables and the unused stall bits do not affect this stage's outputs
    logic unused_bits;
    assign unused_bits = ^{bus_r[145:143], bus_r[44:43], stall[5], stall[2:0]};

    // Load extraction: pick byte/halfword lane from ram_sel, then extend
    logic [31:0] rd;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    always_comb begin
        rd        = hold_vld ? rdata_hold : data_sram_rdata;
        byte_v    = 8'h00;
        half_v    = 16'h0000;
        load_data = 32'h0000_0000;
        case (ram_sel)
            4'b0001: byte_v = rd[7:0];
            4'b0010: byte_v = rd[15:8];
            4'b0100: byte_v = rd[23:16];
            4'b1000: byte_v = rd[31:24];
            default: byte_v = 8'h00;
        endcase
        if (ram_sel[2]) begin
            half_v = rd[31:16];
        end else if (ram_sel[0]) begin
            half_v = rd[15:0];
        end
        if (op_lb) begin
            load_data = {{24{byte_v[7]}}, byte_v};
        end else if (op_lbu) begin
            load_data = {24'h0, byte_v};
        end else if (op_lh) begin
            load_data = {{16{half_v[15]}}, half_v};
        end else if (op_lhu) begin
            load_data = {16'h0, half_v};
        end else if (op_lw) begin
            load_data = rd;
        end
    end

    // Exception gating suppresses every architectural write of the faulting instruction
    logic [31:0] rf_wdata;
    logic [65:0] hilo_out;
    logic        rf_we_out;
    assign except_valid = |excepttype[15:6];
    assign rf_wdata     = sel_rf_res ? load_data : ex_result;
    assign rf_we_out    = rf_we & ~except_valid;
    assign hilo_out     = {hi_we & ~except_valid, hi_data, lo_we & ~except_valid, lo_data};

    assign mem_to_wb_bus = {hilo_out, pc, rf_we_out, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {hilo_out, rf_we_out, rf_waddr, rf_wdata};
    assign excepttype_o  = excepttype;
    assign except_pc     = pc;
    assign bad_vaddr     = excepttype[9] ? pc : ex_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed and random stimulus
module tb_mem_stage;

    localparam logic [7:0] OP_LB  = 8'h80;
    localparam logic [7:0] OP_LBU = 8'h40;
    localparam logic [7:0] OP_LH  = 8'h20;
    localparam logic [7:0] OP_LHU = 8'h10;
    localparam logic [7:0] OP_LW  = 8'h08;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [5:0]   stall = 6'b0;
    logic [166:0] ex_to_mem_bus = '0;
    logic [31:0]  data_sram_rdata = '0;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_rf_bus;
    logic         except_valid;
    logic [15:0]  excepttype_o;
    logic [31:0]  except_pc;
    logic [31:0]  bad_vaddr;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stall          (stall),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_bus  (mem_to_wb_bus),
        .mem_to_rf_bus  (mem_to_rf_bus),
        .except_valid   (except_valid),
        .excepttype_o   (excepttype_o),
        .except_pc      (except_pc),
        .bad_vaddr      (bad_vaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [135:0] wb;
        logic [103:0] rf;
        logic         ev;
        logic [15:0]  et;
        logic [31:0]  epc;
        logic [31:0]  bva;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the instruction occupying MEM and the data word it is entitled to
    logic [166:0] m_bus = '0;
    logic         m_held = 1'b0;
    logic [31:0]  m_rd = '0;

    function automatic logic [166:0] mk(input logic [15:0] et, input logic [7:0] op,
                                        input logic hw, input logic [31:0] hi,
                                        input logic lw_, input logic [31:0] lo,
                                        input logic [31:0] pc, input logic [3:0] sel,
                                        input logic selres, input logic we,
                                        input logic [4:0] wa, input logic [31:0] res);
        return {et, op, hw, hi, lw_, lo, pc, 1'b1, 1'b0, sel, selres, we, wa, res};
    endfunction

    function automatic exp_t predict(input logic [166:0] b, input logic [31:0] rd);
        exp_t e;
        logic [15:0] et;
        logic [7:0]  op;
        logic [3:0]  sel;
        logic [31:0] ld;
        logic [31:0] wd;
        logic [7:0]  by;
        logic [15:0] hw;
        logic        ev;
        int          idx;
        et  = b[166:151];
        op  = b[150:143];
        sel = b[42:39];
        ev  = (et >> 6) != 16'd0;
        idx = -1;
        for (int i = 0; i < 4; i++) if (sel == (4'd1 << i)) idx = i;
        by  = (idx >= 0) ? 8'((rd >> (8 * idx)) & 32'hFF) : 8'h00;
        hw  = sel[2] ? rd[31:16] : (sel[0] ? rd[15:0] : 16'h0);
        ld  = 32'h0;
        if (op == OP_LB)       ld = 32'($signed(by));
        else if (op == OP_LBU) ld = 32'(by);
        else if (op == OP_LH)  ld = 32'($signed(hw));
        else if (op == OP_LHU) ld = 32'(hw);
        else if (op == OP_LW)  ld = rd;
        wd = b[38] ? ld : b[31:0];
        e.rf  = {b[142] && !ev, b[141:110], b[109] && !ev, b[108:77], b[37] && !ev, b[36:32], wd};
        e.wb  = {e.rf[103:38], b[76:45], e.rf[37:0]};
        e.ev  = ev;
        e.et  = et;
        e.epc = b[76:45];
        e.bva = et[9] ? b[76:45] : b[31:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // One cycle: advance the model across the edge, apply new inputs, queue the expected outputs
    task automatic step(input logic r, input logic f, input logic [5:0] s,
                        input logic [166:0] b, input logic [31:0] rdv);
        @(posedge clk);
        #1;
        if (rst || flush) begin
            m_bus = '0; m_held = 1'b0;
        end else if (!stall[3]) begin
            m_bus = ex_to_mem_bus; m_held = 1'b0;
        end else if (!stall[4]) begin
            m_bus = '0; m_held = 1'b0;
        end else if (!m_held) begin
            m_held = 1'b1; m_rd = data_sram_rdata;
        end
        rst = r; flush = f; stall = s; ex_to_mem_bus = b; data_sram_rdata = rdv;
        exp_q.push_back(predict(m_bus, m_held ? m_rd : rdv));
    endtask

    // Monitor: compare whatever the stage presents against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_bus", mem_to_wb_bus, e.wb);
            chk("rf_bus", 136'(mem_to_rf_bus), 136'(e.rf));
            chk("except_valid", 136'(except_valid), 136'(e.ev));
            chk("excepttype_o", 136'(excepttype_o), 136'(e.et));
            chk("except_pc", 136'(except_pc), 136'(e.epc));
            chk("bad_vaddr", 136'(bad_vaddr), 136'(e.bva));
        end
    end

    logic [166:0] nz;
    logic [166:0] b_lw;

    initial begin
        nz   = mk(16'hFFFF, OP_LW, 1'b1, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 32'hBFC0_0000,
                  4'hF, 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D);
        b_lw = mk(16'h0, OP_LW, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0010, 4'hF, 1'b1, 1'b1,
                  5'd3, 32'h0000_1000);

        // Reset with a nonzero incoming bus
        step(1'b1, 1'b0, 6'b0, nz, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 6'b0, nz, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("reset_wb", mem_to_wb_bus, 136'h0);
        chk("reset_ev", 136'(except_valid), 136'h0);
        chk("reset_bva", 136'(bad_vaddr), 136'h0);

        // lb sign extension from byte lane 2
        step(1'b0, 1'b0, 6'b0, mk(16'h0, OP_LB, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0000,
                                  4'b0100, 1'b1, 1'b1, 5'd5, 32'h0000_0102), 32'h0);
        step(1'b0, 1'b0, 6'b0, mk(16'h0, OP_LHU, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0004,
                                  4'b1100, 1'b1, 1'b1, 5'd6, 32'h0000_0202), 32'h1280_3456);
        @(negedge clk);
        chk("lb_wdata", 136'(mem_to_wb_bus[31:0]), 136'hFFFF_FF80);
        chk("lb_we", 136'(mem_to_wb_bus[37]), 136'h1);
        chk("lb_waddr", 136'(mem_to_wb_bus[36:32]), 136'h5);

        // lhu upper half, then lw
        step(1'b0, 1'b0, 6'b0, b_lw, 32'h8001_7FFF);
        @(negedge clk);
        chk("lhu_wdata", 136'(mem_to_wb_bus[31:0]), 136'h0000_8001);
        step(1'b0, 1'b0, 6'b0, b_lw, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lw_wdata", 136'(mem_to_wb_bus[31:0]), 136'hDEAD_BEEF);

        // Stall hold: MEM stopped for 3 cycles, first-cycle data must persist through release
        step(1'b0, 1'b0, 6'b011000, nz, 32'h1111_1111);
        @(negedge clk);
        chk("hold_c1", 136'(mem_to_wb_bus[31:0]), 136'h1111_1111);
        for (int i = 2; i <= 3; i++) begin
            step(1'b0, 1'b0, 6'b011000, nz, 32'h2222_2222);
            @(negedge clk);
            chk("hold_cn", 136'(mem_to_wb_bus[31:0]), 136'h1111_1111);
        end
        step(1'b0, 1'b0, 6'b0, b_lw, 32'h2222_2222);
        @(negedge clk);
        chk("hold_release", 136'(mem_to_wb_bus[31:0]), 136'h1111_1111);

        // Bubble from EX-only stall
        step(1'b0, 1'b0, 6'b001000, nz, 32'h0);
        step(1'b0, 1'b0, 6'b0, b_lw, 32'h5555_5555);
        @(negedge clk);
        chk("bubble_wb", mem_to_wb_bus, 136'h0);

        // Flush wins over a loading stall vector and discards held data
        step(1'b0, 1'b0, 6'b011000, b_lw, 32'h3333_3333);
        step(1'b0, 1'b1, 6'b011000, b_lw, 32'h4444_4444);
        step(1'b0, 1'b0, 6'b0, b_lw, 32'h6666_6666);
        @(negedge clk);
        chk("flush_wb", mem_to_wb_bus, 136'h0);
        step(1'b0, 1'b0, 6'b011000, nz, 32'h7777_7777);
        @(negedge clk);
        chk("after_flush_live", 136'(mem_to_wb_bus[31:0]), 136'h7777_7777);

        // Exception gating: address error on data (bit 7), then on fetch (bit 9)
        step(1'b0, 1'b0, 6'b0, mk(16'h0080, 8'h0, 1'b1, 32'hAAAA_0000, 1'b1, 32'h0000_BBBB,
                                  32'h0040_0100, 4'hF, 1'b0, 1'b1, 5'd7, 32'h0000_0003), 32'h0);
        step(1'b0, 1'b0, 6'b0, mk(16'h0200, 8'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'hBFC0_0001,
                                  4'hF, 1'b0, 1'b1, 5'd8, 32'h0000_0044), 32'h0);
        @(negedge clk);
        chk("exc7_valid", 136'(except_valid), 136'h1);
        chk("exc7_rf_we", 136'(mem_to_wb_bus[37]), 136'h0);
        chk("exc7_hi_we", 136'(mem_to_wb_bus[135]), 136'h0);
        chk("exc7_lo_we", 136'(mem_to_wb_bus[102]), 136'h0);
        chk("exc7_bva", 136'(bad_vaddr), 136'h0000_0003);
        step(1'b0, 1'b0, 6'b0, b_lw, 32'h0);
        @(negedge clk);
        chk("exc9_valid", 136'(except_valid), 136'h1);
        chk("exc9_bva", 136'(bad_vaddr), 136'hBFC0_0001);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [7:0]  op;
            logic [3:0]  sel;
            logic [15:0] et;
            logic [5:0]  s;
            logic        r, f;
            case ($urandom_range(0, 6))
                0: op = OP_LB;
                1: op = OP_LBU;
                2: op = OP_LH;
                3: op = OP_LHU;
                4: op = OP_LW;
                5: op = 8'h01 << $urandom_range(0, 2);
                default: op = 8'h00;
            endcase
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(4'd1 << $urandom_range(0, 3));
            et  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            s   = 6'($urandom) & 6'b100111;
            case ($urandom_range(0, 7))
                0, 1: s = s | 6'b011000;
                2:    s = s | 6'b001000;
                default: ;
            endcase
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 24) == 0);
            step(r, f, s,
                 mk(et, op, 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                    sel, 1'($urandom), 1'($urandom), 5'($urandom), $urandom),
                 $urandom);
        end

        step(1'b0, 1'b0, 6'b0, '0, 32'h0);
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
